// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-outstanding APB3/APB4 requester. Turns a valid/ready command
//   stream into one APB SETUP/ACCESS transfer at a time and returns the
//   result on a valid/ready response stream. A wait-state timeout aborts
//   transfers whose responder never raises PREADY.
//
// Parameters
//   TIMEOUT   max consecutive ACCESS cycles with PREADY=0 before abort (0 = never)
//
// Ports
//   PCLK, PRESET                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_addr/write/wdata/strb/prot    command payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata/err/timeout             response payload
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PSTRB, PPROT              APB requester outputs (registered)
//   PRDATA, PREADY, PSLVERR           APB responder inputs
module apb_master_bridge #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_write,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_strb,
   input  logic [2:0]  cmd_prot,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   output logic [2:0]  PPROT,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   // Counter only has to reach TIMEOUT-1.
   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT != 0) ? CW'(TIMEOUT - 1) : '0;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic           psel_d, penable_d, pwrite_d;
   logic [31:0]    paddr_d, pwdata_d;
   logic [3:0]     pstrb_d;
   logic [2:0]     pprot_d;
   logic           rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic [31:0]    rsp_rdata_d;

   logic           timeout_hit;

   assign cmd_ready   = (state_q == IDLE) && !PRESET;
   assign timeout_hit = (TIMEOUT != 0) && !PREADY && (cnt_q == CNT_LAST);

   // State and registered outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         PPROT       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         PSEL        <= psel_d;
         PENABLE     <= penable_d;
         PWRITE      <= pwrite_d;
         PADDR       <= paddr_d;
         PWDATA      <= pwdata_d;
         PSTRB       <= pstrb_d;
         PPROT       <= pprot_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_valid) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (PREADY || timeout_hit) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of registered outputs and wait counter
   always_comb begin
      cnt_d         = cnt_q;
      psel_d        = PSEL;
      penable_d     = PENABLE;
      pwrite_d      = PWRITE;
      paddr_d       = PADDR;
      pwdata_d      = PWDATA;
      pstrb_d       = PSTRB;
      pprot_d       = PPROT;
      rsp_valid_d   = rsp_valid;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d   = cmd_addr;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_wdata;
               pprot_d   = cmd_prot;
               pstrb_d   = cmd_write ? cmd_strb : 4'h0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ACCESS: begin
            if (PREADY) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_rdata_d   = PWRITE ? 32'h0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
            end else if (timeout_hit) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
            end else if (TIMEOUT != 0) begin
               // With the timeout disabled the counter is frozen so it never wraps.
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB3/APB4 requester. Converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns each result on a valid/ready response stream.
- Drives the APB memory and peripheral responders on the PCLK domain; serves as the initiator for bus-level tests and for simple control masters.
- Includes a wait-state timeout, so a hung responder cannot stall the initiator.

Parameters:
- TIMEOUT, 16: maximum consecutive ACCESS cycles with PREADY=0 before the transfer is aborted; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_addr  in  32  byte address, passed unmodified to PADDR
- cmd_write  in  1  1=write, 0=read
- cmd_wdata  in  32  write data
- cmd_strb  in  4  byte strobes for writes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR, PWDATA  out  32 each  APB address and write data
- PSTRB  out  4  APB4 strobes
- PPROT  out  3  APB4 protection
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (PRESET=1 at an edge): state=IDLE, wait counter=0. All registered outputs are 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, rsp_timeout. Reset has priority over every other event.
- cmd_ready = (state==IDLE) & ~PRESET. It is combinational from the state register only and never depends on cmd_valid.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On an accept, register cmd_addr, cmd_write, cmd_wdata and cmd_prot into PADDR, PWRITE, PWDATA and PPROT.
  - PSTRB <= cmd_write ? cmd_strb : 4'h0; reads always drive PSTRB=0.
  - PSEL <= 1, PENABLE <= 0, go to SETUP.
- SETUP (exactly 1 cycle): PENABLE <= 1, wait counter <= 0, go to ACCESS.
- ACCESS:
  - PREADY=1: PSEL <= 0, PENABLE <= 0.
  - Same PREADY=1 case: rsp_rdata <= PWRITE ? 0 : PRDATA, rsp_err <= PSLVERR, rsp_timeout <= 0, rsp_valid <= 1, go to RESP.
  - PREADY=0 and TIMEOUT!=0 and counter==TIMEOUT-1: abort. PSEL <= 0, PENABLE <= 0, rsp_rdata <= 0, rsp_err <= 1, rsp_timeout <= 1, rsp_valid <= 1, go to RESP.
  - Otherwise: counter <= counter+1, stay in ACCESS.
  - The counter is wide enough for TIMEOUT−1 and must not wrap while TIMEOUT=0.
- RESP: hold rsp_* stable until rsp_ready=1. At the handshake edge, rsp_valid <= 0 and go to IDLE. rsp_ready=1 on the edge rsp_valid rises has no effect; the handshake counts only while rsp_valid=1.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT are stable from SETUP through the end of ACCESS. After a transfer they hold their last values until the next accept.
- Latency with zero wait states:
  - accept edge N
  - SETUP visible in cycle N+1
  - ACCESS in cycle N+2
  - rsp_valid=1 from cycle N+3
  - cmd_ready=1 again in the cycle after the response handshake
- Minimum spacing between PSEL assertions is 4 cycles. There are no back-to-back transfers.
- PRDATA and PSLVERR are sampled only at the edge where PENABLE=1 and PREADY=1. PREADY in IDLE or SETUP is ignored.
- Reset mid-transfer: PSEL and PENABLE drop at the reset edge. Any pending response is discarded (rsp_valid=0).
- cmd_valid asserted outside IDLE is not accepted. The command must be held by the source (standard valid/ready).

Test Plan:
- Zero-wait write (addr=0x10, data=0xA5A5_1234, strb=0xF; responder PREADY=1) -> PSEL high 2 cycles, PENABLE high in cycle 2 only, PSTRB=0xF, rsp_err=0, rsp_rdata=0.
- Read-after-write with 2 wait states (addr=0x10) -> ACCESS lasts 3 cycles, rsp_rdata=0xA5A5_1234, PSTRB=0 throughout.
- Partial write strb=0x3, data=0xFFFF_BEEF to 0x20 over prior 0x1111_1111, then read -> rsp_rdata=0x1111_BEEF.
- Responder asserts PSLVERR=1 with PREADY -> rsp_err=1, rsp_timeout=0; rsp_ready held low 5 cycles -> rsp_* stable and cmd_ready=0 throughout.
- TIMEOUT=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0; next command then proceeds normally.
- PRESET=1 during ACCESS -> PSEL, PENABLE and rsp_valid all 0 at the next edge, state=IDLE, cmd_ready=1 once PRESET=0.
